rr_mux_arbiter: RTL and testbench



---
 rtl/rr_mux_arbiter_pkg.sv | 28 ++
 rtl/rr_mux_arbiter_if.sv | 13 +
 rtl/rr_mux_arbiter_mux4_1.sv | 11 +
 rtl/rr_mux_arbiter.sv | 115 +++++++++++
 tb/tb_rr_mux_arbiter.sv | 113 +++++++++++
 5 files changed

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and the round-robin search helper for the 4-requester mux arbiter.
package rr_mux_arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First set request at or after start, wrapping 3 -> 0.
  function automatic pick_t next_req(input logic [SEL_W-1:0] start,
                                     input logic [NUM_REQ-1:0] req);
    pick_t            r;
    logic [SEL_W-1:0] k;
    r = '0;
    for (int n = NUM_REQ - 1; n >= 0; n--) begin
      k = start + SEL_W'(n);
      if (req[k]) begin
        r.found = 1'b1;
        r.idx   = k;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester/mux bundle between the arbiter (slave) and its requesters (master).
interface rr_mux_arbiter_if;
  import rr_mux_arb_pkg::*;
  logic [NUM_REQ-1:0] req;
  logic               i0, i1, i2, i3;
  logic [SEL_W-1:0]   s;
  logic [NUM_REQ-1:0] gnt;
  logic               busy;
  logic               out;

  modport master (output req, i0, i1, i2, i3, input s, gnt, busy, out);
  modport slave  (input req, i0, i1, i2, i3, output s, gnt, busy, out);
endinterface

// File: rtl/rr_mux_arbiter_mux4_1.sv
// Plain combinational 4:1 one-bit multiplexer.
module mux4_1 (
  input  logic       i0,
  input  logic       i1,
  input  logic       i2,
  input  logic       i3,
  input  logic [1:0] s,
  output logic       y
);
  assign y = s[1] ? (s[0] ? i3 : i2) : (s[0] ? i1 : i0);
endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin owner of a shared 4:1 mux select with a bounded hold window.
// state | meaning
// IDLE  | no grant, s keeps last grantee
// GRANT | gnt[s] asserted, cnt counts cycles in the current hold window
module rr_mux_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input logic             clk,
  input logic             rst,
  rr_mux_arbiter_if.slave bus
);
  import rr_mux_arb_pkg::*;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   s_q, s_d, ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               mux_y;

  pick_t              pick_idle, pick_next;
  logic               take;
  logic [SEL_W-1:0]   win;

  assign pick_idle = next_req(ptr_q, bus.req);
  // Current grantee is masked so "another request pending" excludes it.
  assign pick_next = next_req(s_q + SEL_W'(1), bus.req & ~(NUM_REQ'(1) << s_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    take    = 1'b0;
    win     = '0;
    case (state_q)
      IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (pick_idle.found) begin
          take = 1'b1;
          win  = pick_idle.idx;
        end
      end
      GRANT: begin
        if (!bus.req[s_q]) begin
          if (pick_next.found) begin
            take = 1'b1;
            win  = pick_next.idx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
          end
        end else if (cnt_q == 4'(MAX_HOLD)) begin
          if (pick_next.found) begin
            take = 1'b1;
            win  = pick_next.idx;
          end else begin
            cnt_d = 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
    if (take) begin
      state_d = GRANT;
      s_d     = win;
      gnt_d   = NUM_REQ'(1) << win;
      cnt_d   = 4'd1;
      ptr_d   = win + SEL_W'(1);
      busy_d  = 1'b1;
    end
  end

  mux4_1 u_mux (
    .i0 (bus.i0),
    .i1 (bus.i1),
    .i2 (bus.i2),
    .i3 (bus.i3),
    .s  (s_q),
    .y  (mux_y)
  );

  assign bus.s    = s_q;
  assign bus.gnt  = gnt_q;
  assign bus.busy = busy_q;
  assign bus.out  = mux_y & busy_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed vector bench for rr_mux_arbiter (MAX_HOLD=4 plus a MAX_HOLD=1 instance).
module tb_rr_mux_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst1 = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter_if bus0 ();
  rr_mux_arbiter_if bus1 ();

  rr_mux_arbiter #(.MAX_HOLD(4)) dut  (.clk(clk), .rst(rst),  .bus(bus0));
  rr_mux_arbiter #(.MAX_HOLD(1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       busy;
    logic       out;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic r, logic [3:0] q, logic [3:0] d,
                              logic [3:0] g, logic [1:0] s, logic b, logic o);
    vec_t v;
    v.rst = r; v.req = q; v.din = d; v.gnt = g; v.s = s; v.busy = b; v.out = o;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(vec_t v, int idx);
    rst      = v.rst;
    bus0.req = v.req;
    bus0.i0  = v.din[0];
    bus0.i1  = v.din[1];
    bus0.i2  = v.din[2];
    bus0.i3  = v.din[3];
    @(posedge clk);
    #1;
    chk("gnt",  idx, bus0.gnt,          v.gnt);
    chk("s",    idx, {2'b00, bus0.s},   {2'b00, v.s});
    chk("busy", idx, {3'b000, bus0.busy}, {3'b000, v.busy});
    chk("out",  idx, {3'b000, bus0.out},  {3'b000, v.out});
  endtask

  initial begin
    bus0.req = '0; bus0.i0 = 0; bus0.i1 = 0; bus0.i2 = 0; bus0.i3 = 0;
    bus1.req = '0; bus1.i0 = 0; bus1.i1 = 0; bus1.i2 = 0; bus1.i3 = 0;

    //               rst req      din      gnt      s  busy out
    // reset held with all requesting, then first grant goes to 0
    tv.push_back(mk(1, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0));
    tv.push_back(mk(1, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0));
    tv.push_back(mk(0, 4'b1111, 4'b0001, 4'b0001, 0, 1, 1));
    tv.push_back(mk(0, 4'b0000, 4'b0001, 4'b0000, 0, 0, 0));
    // single requester 2, i2 toggling, window renews silently
    for (int k = 0; k < 10; k++)
      tv.push_back(mk(0, 4'b0100, (k % 2 == 0) ? 4'b0100 : 4'b0000,
                      4'b0100, 2, 1, (k % 2 == 0)));
    tv.push_back(mk(0, 4'b0000, 4'b0100, 4'b0000, 2, 0, 0));
    // reset, then full round robin 0,1,2,3,0 with 4-cycle holds
    tv.push_back(mk(1, 4'b0000, 4'b1010, 4'b0000, 0, 0, 0));
    for (int k = 0; k < 17; k++)
      tv.push_back(mk(0, 4'b1111, 4'b1010, 4'b0001 << ((k / 4) % 4),
                      2'((k / 4) % 4), 1, ((k / 4) % 2 == 1)));
    // early release of 0 hands straight to 1
    tv.push_back(mk(0, 4'b0011, 4'b1010, 4'b0001, 0, 1, 0));
    tv.push_back(mk(0, 4'b0010, 4'b1010, 4'b0010, 1, 1, 1));
    // handover to 3, idle, then wrap: 1001 picks 0, ptr then 1
    tv.push_back(mk(0, 4'b1000, 4'b1010, 4'b1000, 3, 1, 1));
    tv.push_back(mk(0, 4'b0000, 4'b1010, 4'b0000, 3, 0, 0));
    tv.push_back(mk(0, 4'b1001, 4'b1011, 4'b0001, 0, 1, 1));
    tv.push_back(mk(0, 4'b0000, 4'b1011, 4'b0000, 0, 0, 0));
    tv.push_back(mk(0, 4'b1011, 4'b1011, 4'b0010, 1, 1, 1));

    foreach (tv[n]) apply(tv[n], n);

    // reset during the second cycle of a hold drops the grant at once
    apply(mk(0, 4'b0100, 4'b0100, 4'b0100, 2, 1, 1), 100);
    apply(mk(1, 4'b0100, 4'b0100, 4'b0000, 0, 0, 0), 101);
    apply(mk(0, 4'b1000, 4'b1000, 4'b1000, 3, 1, 1), 102);
    apply(mk(0, 4'b1000, 4'b0000, 4'b1000, 3, 1, 0), 103);

    // MAX_HOLD=1 with everyone requesting rotates every cycle
    rst1 = 1'b1;
    bus1.req = 4'b1111;
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      chk("hold1_gnt", 200 + k, bus1.gnt, 4'b0001 << (k % 4));
      chk("hold1_s",   200 + k, {2'b00, bus1.s}, 4'(k % 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
